// File: rtl/fifo_stream_reader_if.sv
// Output stream bundle for fifo_stream_reader.
// The master drives m_valid/m_data and the slave drives m_ready.
// A word transfers on a clock edge where both m_valid and m_ready are high.
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a simple-DP-RAM FIFO with fixed read latency.
// It issues read strobes only when a buffer slot is guaranteed for the
// returning word. It captures each word LATENCY cycles after its strobe
// and presents the buffered words as a valid/ready stream.
//
// Ports:
//   clk, reset_n    clock and asynchronous active-low reset
//   enable          permits issuing new FIFO reads
//   fifo_empty      FIFO empty flag
//   fifo_read       FIFO read strobe
//   fifo_read_data  FIFO read data, valid LATENCY cycles after the strobe
//   m               output stream (m_valid / m_ready / m_data)
//   buf_count       entries currently held in the output buffer
//   idle            no reads in flight and buffer empty
module fifo_stream_reader #(
    parameter int unsigned  DATA_WIDTH = 8,
    parameter int unsigned  LATENCY    = 1,
    parameter int unsigned  BUF_DEPTH  = LATENCY + 2,
    localparam int unsigned CNT_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    fifo_stream_reader_if.master  m,
    output logic [CNT_W-1:0]      buf_count,
    output logic                  idle
);

    localparam int unsigned IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned INF_W = $clog2(LATENCY + 1);
    localparam int unsigned SUM_W = $clog2(LATENCY + BUF_DEPTH + 1);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  active;
    logic [LATENCY-1:0]    tracker;
    logic [INF_W-1:0]      inflight;
    logic                  credit_ok;
    logic                  capture;
    logic                  pop;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];

    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(BUF_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
    endfunction

    // Start-up gate: reads stay off until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD: state_nxt = ST_RUN;
            default: state_nxt = state;
        endcase
    end

    always_comb begin
        active = 1'b0;
        if (state == ST_RUN) begin
            active = 1'b1;
        end
    end

    // In-flight tracker: one bit per outstanding read, top bit = word arriving now.
    generate
        if (LATENCY == 1) begin : g_trk_one
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    tracker <= '0;
                end else begin
                    tracker <= fifo_read;
                end
            end
        end else begin : g_trk_multi
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    tracker <= '0;
                end else begin
                    tracker <= {tracker[LATENCY-2:0], fifo_read};
                end
            end
        end
    endgenerate

    always_comb begin
        inflight = '0;
        for (int unsigned i = 0; i < LATENCY; i++) begin
            inflight = inflight + INF_W'(tracker[i]);
        end
    end

    // Credit: every outstanding read owns a free slot, so capture never overflows.
    // Deliberately independent of m_ready to keep the strobe path short.
    assign credit_ok = (SUM_W'(inflight) + SUM_W'(buf_count)) < SUM_W'(BUF_DEPTH);
    assign fifo_read = active & enable & ~fifo_empty & credit_ok;

    assign capture = tracker[LATENCY-1];
    assign pop     = m.m_valid & m.m_ready;

    // Circular output buffer with occupancy count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            buf_count <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            if (capture) begin
                buf_mem[wr_idx] <= fifo_read_data;
                wr_idx          <= inc_idx(wr_idx);
            end
            if (pop) begin
                rd_idx <= inc_idx(rd_idx);
            end
            case ({capture, pop})
                2'b10:   buf_count <= buf_count + CNT_W'(1);
                2'b01:   buf_count <= buf_count - CNT_W'(1);
                default: buf_count <= buf_count;
            endcase
        end
    end

    assign m.m_valid = (buf_count != '0);
    assign m.m_data  = buf_mem[rd_idx];
    assign idle      = (inflight == '0) && (buf_count == '0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: two instances (LATENCY=1/BUF_DEPTH=3 and
// LATENCY=3/BUF_DEPTH=5), each fed by a behavioural latency FIFO. Words
// loaded into a FIFO are also queued as expected output; a monitor per
// instance pops and compares every accepted output word.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    logic rst_n;
    logic enable;

    // Instance 0: LATENCY=1, BUF_DEPTH=3
    logic       fifo_empty0 = 1'b1;
    logic       fifo_read0;
    logic [7:0] frd0;
    logic [1:0] bc0;
    logic       idle0;
    fifo_stream_reader_if #(.DATA_WIDTH(8)) s0 ();

    // Instance 1: LATENCY=3, BUF_DEPTH=5
    logic       fifo_empty1 = 1'b1;
    logic       fifo_read1;
    logic [7:0] frd1;
    logic [2:0] bc1;
    logic       idle1;
    fifo_stream_reader_if #(.DATA_WIDTH(8)) s1 ();

    fifo_stream_reader #(.DATA_WIDTH(8), .LATENCY(1), .BUF_DEPTH(3)) u0 (
        .clk(clk), .reset_n(rst_n), .enable(enable), .fifo_empty(fifo_empty0),
        .fifo_read(fifo_read0), .fifo_read_data(frd0), .m(s0),
        .buf_count(bc0), .idle(idle0)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .LATENCY(3), .BUF_DEPTH(5)) u1 (
        .clk(clk), .reset_n(rst_n), .enable(enable), .fifo_empty(fifo_empty1),
        .fifo_read(fifo_read1), .fifo_read_data(frd1), .m(s1),
        .buf_count(bc1), .idle(idle1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int deliv0 = 0;
    int deliv1 = 0;

    logic [7:0] fq0[$];
    logic [7:0] eq0[$];
    logic [7:0] fq1[$];
    logic [7:0] eq1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [7:0] w);
        fq0.push_back(w);
        eq0.push_back(w);
    endtask

    task automatic push1(input logic [7:0] w);
        fq1.push_back(w);
        eq1.push_back(w);
    endtask

    // FIFO model 0: read data appears one cycle after the strobe.
    logic [7:0] pd0 = 8'hEE;
    logic       pv0 = 1'b0;
    assign frd0 = pd0;

    always @(posedge clk) begin : fifo_model0
        logic [7:0] w;
        w = 8'hEE;
        if (fifo_read0) begin
            if (fq0.size() == 0) begin
                errors++;
                $display("FAIL read_empty0: strobe while model FIFO empty");
            end else begin
                w = fq0.pop_front();
            end
        end
        assert (!(rst_n && pv0 && bc0 == 2'd3)) else begin
            errors++;
            $display("FAIL cap_full0: capture with buf_count %0d required < 3", bc0);
        end
        pd0         <= w;
        pv0         <= fifo_read0;
        fifo_empty0 <= (fq0.size() == 0);
    end

    // FIFO model 1: read data appears three cycles after the strobe.
    logic [7:0] pd1 [3];
    logic [2:0] pv1 = 3'b000;
    assign frd1 = pd1[2];

    always @(posedge clk) begin : fifo_model1
        logic [7:0] w;
        w = 8'hEE;
        if (fifo_read1) begin
            if (fq1.size() == 0) begin
                errors++;
                $display("FAIL read_empty1: strobe while model FIFO empty");
            end else begin
                w = fq1.pop_front();
            end
        end
        assert (!(rst_n && pv1[2] && bc1 == 3'd5)) else begin
            errors++;
            $display("FAIL cap_full1: capture with buf_count %0d required < 5", bc1);
        end
        pd1[0]      <= w;
        pd1[1]      <= pd1[0];
        pd1[2]      <= pd1[1];
        pv1         <= {pv1[1:0], fifo_read1};
        fifo_empty1 <= (fq1.size() == 0);
    end

    // Scoreboard monitors: compare each accepted word against the expected queue.
    always @(negedge clk) begin
        if (rst_n && s0.m_valid && s0.m_ready) begin
            deliv0++;
            if (eq0.size() == 0) begin
                errors++;
                $display("FAIL extra_word0: got 0x%0h with nothing expected", s0.m_data);
            end else begin
                chk("m_data0", 32'(s0.m_data), 32'(eq0.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && s1.m_valid && s1.m_ready) begin
            deliv1++;
            if (eq1.size() == 0) begin
                errors++;
                $display("FAIL extra_word1: got 0x%0h with nothing expected", s1.m_data);
            end else begin
                chk("m_data1", 32'(s1.m_data), 32'(eq1.pop_front()));
            end
        end
    end

    task automatic wait_drain0(input string name, input int budget);
        int n;
        n = 0;
        while (!(idle0 && eq0.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    int rd_tot, rd_run, rd_max, v_tot, v_run, v_max, start, n;

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b1;
        s0.m_ready  = 1'b1;
        s1.m_ready  = 1'b0;

        // Single word
        push0(8'hA5);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst fifo_read", 32'(fifo_read0), 32'd0);
        chk("rst m_valid", 32'(s0.m_valid), 32'd0);
        chk("rst m_data", 32'(s0.m_data), 32'd0);
        chk("rst buf_count", 32'(bc0), 32'd0);
        chk("rst idle", 32'(idle0), 32'd1);
        chk("rst m_valid1", 32'(s1.m_valid), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("c0 fifo_read", 32'(fifo_read0), 32'd0);
        @(negedge clk); chk("c1 fifo_read", 32'(fifo_read0), 32'd1);
        @(negedge clk); chk("c2 fifo_read", 32'(fifo_read0), 32'd0);
        chk("c2 m_valid", 32'(s0.m_valid), 32'd0);
        @(negedge clk); chk("c3 m_valid", 32'(s0.m_valid), 32'd1);
        chk("c3 m_data", 32'(s0.m_data), 32'hA5);
        @(negedge clk); chk("c4 m_valid", 32'(s0.m_valid), 32'd0);
        chk("c4 idle", 32'(idle0), 32'd1);

        // Streaming: 16 words, no gaps on either side
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) push0(8'(i));
        rd_tot = 0; rd_run = 0; rd_max = 0; v_tot = 0; v_run = 0; v_max = 0;
        repeat (30) begin
            @(negedge clk);
            if (fifo_read0) begin rd_tot++; rd_run++; end else rd_run = 0;
            if (rd_run > rd_max) rd_max = rd_run;
            if (s0.m_valid) begin v_tot++; v_run++; end else v_run = 0;
            if (v_run > v_max) v_max = v_run;
        end
        chk("stream strobes", 32'(rd_tot), 32'd16);
        chk("stream strobe run", 32'(rd_max), 32'd16);
        chk("stream valids", 32'(v_tot), 32'd16);
        chk("stream valid run", 32'(v_max), 32'd16);
        wait_drain0("stream drain", 50);

        // Backpressure: only BUF_DEPTH strobes while m_ready is low
        @(posedge clk); #1;
        s0.m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push0(8'(8'h40 + i));
        rd_tot = 0;
        repeat (12) begin
            @(negedge clk);
            if (fifo_read0) rd_tot++;
        end
        chk("bp strobes", 32'(rd_tot), 32'd3);
        chk("bp buf_count", 32'(bc0), 32'd3);
        chk("bp m_valid", 32'(s0.m_valid), 32'd1);
        chk("bp head", 32'(s0.m_data), 32'h40);
        start = deliv0;
        @(posedge clk); #1 s0.m_ready = 1'b1;
        wait_drain0("bp drain", 80);
        chk("bp delivered", 32'(deliv0 - start), 32'd10);

        // Enable drop the cycle after a strobe
        start = deliv0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) push0(8'(8'h50 + i));
        n = 0;
        do begin @(negedge clk); n++; end while (!fifo_read0 && n < 10);
        chk("en first strobe", 32'(fifo_read0), 32'd1);
        @(posedge clk); #1 enable = 1'b0;
        rd_tot = 0;
        repeat (8) begin
            @(negedge clk);
            if (fifo_read0) rd_tot++;
        end
        chk("en strobes after drop", 32'(rd_tot), 32'd0);
        chk("en delivered", 32'(deliv0 - start), 32'd1);
        chk("en idle", 32'(idle0), 32'd1);
        chk("en m_valid", 32'(s0.m_valid), 32'd0);
        @(posedge clk); #1 enable = 1'b1;
        wait_drain0("en drain", 40);

        // Reset with 2 words buffered and 1 in flight
        @(posedge clk); #1;
        s0.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push0(8'(8'h30 + i));
        n = 0;
        do begin @(negedge clk); n++; end while (bc0 != 2'd2 && n < 10);
        chk("mid bufcount pre", 32'(bc0), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid m_valid", 32'(s0.m_valid), 32'd0);
        chk("mid fifo_read", 32'(fifo_read0), 32'd0);
        chk("mid buf_count", 32'(bc0), 32'd0);
        chk("mid idle", 32'(idle0), 32'd1);
        chk("mid reads issued", 32'(fq0.size()), 32'd5);
        eq0 = fq0;
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        s0.m_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!s0.m_valid && n < 10);
        chk("mid first word", 32'(s0.m_data), 32'h33);
        wait_drain0("mid drain", 40);

        // Deep latency with random backpressure
        @(posedge clk); #1;
        for (int i = 0; i < 200; i++) push1(8'(i * 37 + 11));
        n = 0;
        while (!(eq1.size() == 0 && idle1 && fq1.size() == 0) && n < 3000) begin
            @(posedge clk); #1;
            s1.m_ready = 1'($urandom_range(0, 1));
            n++;
        end
        chk("deep timeout", 32'(n < 3000), 32'd1);
        chk("deep delivered", 32'(deliv1), 32'd200);
        chk("deep idle", 32'(idle1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
